// File: rtl/lane_rr_arbiter_if.sv
// Requester/datapath handshake bundle for lane_rr_arbiter.
// master = requesters plus the datapath ready; slave = the arbiter.
interface lane_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 2
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_ready;
    logic [GW-1:0]                 grant_id;
    logic                          busy;

    modport master (
        output req_valid, req_last, req_data, out_ready,
        input  req_ready, out_valid, out_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_last, req_data, out_ready,
        output req_ready, out_valid, out_data, grant_id, busy
    );
endinterface

// File: rtl/lane_rr_arbiter.sv
// Round-robin burst arbiter sharing one lane datapath among NUM_REQ requesters.
// Optional transfer counter / forced-release flag under LANE_RR_ARBITER_XFER_CNT_EN.
module lane_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 2,
    parameter int MAX_HOLD   = 8
) (
    input  logic               clk,
    input  logic               rst,
    lane_rr_arbiter_if.slave   bus
`ifdef LANE_RR_ARBITER_XFER_CNT_EN
    ,
    output logic [15:0]        xfer_count,
    output logic               force_rel
`endif
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_reg, state_next;
    logic [GW-1:0]   grant_reg, grant_next;
    logic [GW-1:0]   last_ptr_reg, last_ptr_next;
    logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;

    logic [GW-1:0]         winner;
    logic                  any_req;
    int                    idx;
    logic                  active;
    logic                  owner_valid;
    logic                  owner_last;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  xfer;
    logic                  release_now;

    // Outputs are gated by rst so nothing transfers during the reset cycle.
    assign active      = (state_reg == GRANT) && !rst;
    assign owner_valid = bus.req_valid[grant_reg];
    assign owner_last  = bus.req_last[grant_reg];
    assign owner_data  = bus.req_data[grant_reg*DATA_WIDTH +: DATA_WIDTH];

    assign xfer        = active && owner_valid && bus.out_ready;
    assign release_now = xfer && (owner_last || (hold_cnt_reg == HW'(MAX_HOLD - 1)));

    assign bus.out_valid = active && owner_valid;
    assign bus.out_data  = active ? owner_data : '0;
    assign bus.busy      = active;
    assign bus.grant_id  = grant_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = active && (grant_reg == GW'(gi)) && bus.out_ready;
        end
    endgenerate

    // Scan offsets from far to near so the nearest requester after last_ptr wins.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_ptr_reg) + k) % NUM_REQ;
            if (bus.req_valid[idx]) begin
                winner  = GW'(idx);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        last_ptr_next = last_ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next    = GRANT;
                    grant_next    = winner;
                    last_ptr_next = winner;
                    hold_cnt_next = '0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    hold_cnt_next = hold_cnt_reg + HW'(1);
                end
                if (release_now) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            last_ptr_reg <= GW'(NUM_REQ - 1);
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            last_ptr_reg <= last_ptr_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

`ifdef LANE_RR_ARBITER_XFER_CNT_EN
    logic [15:0] xfer_count_reg;
    logic        force_rel_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count_reg <= '0;
            force_rel_reg  <= 1'b0;
        end else begin
            if (xfer) begin
                xfer_count_reg <= xfer_count_reg + 16'd1;
            end
            force_rel_reg <= release_now && !owner_last;
        end
    end

    assign xfer_count = xfer_count_reg;
    assign force_rel  = force_rel_reg;
`endif
endmodule

// File: tb/tb_lane_rr_arbiter.sv
// Bench for lane_rr_arbiter: directed test-plan steps plus random traffic,
// all outputs compared every cycle against a burst-level reference model.
module tb_lane_rr_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int DW       = 2;
    localparam int MAX_HOLD = 8;

    logic clk;
    logic rst;
    lane_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();
`ifdef LANE_RR_ARBITER_XFER_CNT_EN
    logic [15:0] xfer_count;
    logic        force_rel;
`endif

    lane_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef LANE_RR_ARBITER_XFER_CNT_EN
        ,
        .xfer_count (xfer_count),
        .force_rel  (force_rel)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit verbose = 1'b1;

    // Reference model: who owns the lane (-1 = none), rotation pointer, beats in grant.
    int          m_owner = -1;
    int          m_last  = NUM_REQ - 1;
    int          m_gid   = 0;
    int          m_hold  = 0;
    int unsigned m_xfer  = 0;
    bit          m_force = 1'b0;

    logic [NUM_REQ-1:0] acc;
    bit                 xfer_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int from);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(from + k) % NUM_REQ]) return (from + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        logic [NUM_REQ-1:0] e_ready;
        logic               e_valid;
        logic               e_busy;
        logic [DW-1:0]      e_data;
        e_ready = '0;
        e_valid = 1'b0;
        e_busy  = 1'b0;
        e_data  = '0;
        if (!rst && m_owner >= 0) begin
            e_busy            = 1'b1;
            e_valid           = bus.req_valid[m_owner];
            e_data            = bus.req_data[m_owner*DW +: DW];
            e_ready[m_owner]  = bus.out_ready;
        end
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
        chk("out_data", 32'(bus.out_data), 32'(e_data));
        chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
        chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
`ifdef LANE_RR_ARBITER_XFER_CNT_EN
        chk("xfer_count", 32'(xfer_count), m_xfer);
        chk("force_rel", 32'(force_rel), 32'(m_force));
`endif
    endtask

    task automatic model_update();
        int o;
        if (rst) begin
            m_owner = -1; m_last = NUM_REQ - 1; m_gid = 0; m_hold = 0; m_xfer = 0; m_force = 1'b0;
        end else if (m_owner < 0) begin
            m_force = 1'b0;
            if (|bus.req_valid) begin
                m_owner = rr_pick(bus.req_valid, (m_last + 1) % NUM_REQ);
                m_gid   = m_owner;
                m_last  = m_owner;
                m_hold  = 0;
            end
        end else begin
            o = m_owner;
            m_force = 1'b0;
            if (bus.req_valid[o] && bus.out_ready) begin
                m_hold++;
                m_xfer = (m_xfer + 1) & 32'hFFFF;
                if (bus.req_last[o] || m_hold == MAX_HOLD) begin
                    m_force = !bus.req_last[o];
                    m_owner = -1;
                end
            end
        end
    endtask

    // One clock: compare at negedge, advance the model at posedge, return 1 time unit later.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        acc       = bus.req_ready & bus.req_valid;
        xfer_seen = bus.out_valid && bus.out_ready;
        if (verbose && xfer_seen)
            $display("xfer t=%0t grant=%0d data=%0h last=%0b", $time, bus.grant_id,
                     bus.out_data, bus.req_last[bus.grant_id]);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.out_ready = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int          beat [NUM_REQ];
        int          gq [$];
        int          exp_g [4];
        int          n;
        int          fp;
        int          got;
        logic [15:0] exp_w [3];
        bit          prev_busy;

        rst = 1'b1;
        bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Idle after reset.
        do_reset();
        for (int i = 0; i < 5; i++) cycle();
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_grant", 32'(bus.grant_id), 32'd0);

        // Requesters 1 and 3 with 2-beat bursts alternate.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) beat[i] = 0;
        bus.out_ready = 1'b1;
        prev_busy = 1'b0;
        for (int c = 0; c < 14; c++) begin
            bus.req_valid = 4'b1010;
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.req_last[i] = (beat[i] == 1);
                bus.req_data[i*DW +: DW] = DW'(i + beat[i]);
            end
            cycle();
            for (int i = 0; i < NUM_REQ; i++) if (acc[i]) beat[i] = (beat[i] + 1) % 2;
            if (bus.busy && !prev_busy) gq.push_back(int'(bus.grant_id));
            prev_busy = bus.busy;
        end
        exp_g = '{1, 3, 1, 3};
        for (int i = 0; i < 4; i++)
            chk("grant_order", (i < gq.size()) ? 32'(gq[i]) : 32'hFFFF_FFFF, 32'(exp_g[i]));

        // Requester 2 never sends last: forced release after MAX_HOLD beats.
        do_reset();
        bus.req_valid = 4'b0100; bus.req_last = '0; bus.out_ready = 1'b1;
        n = 0; fp = 0; prev_busy = 1'b0;
        for (int c = 0; c < 30; c++) begin
            bus.req_data[2*DW +: DW] = DW'($urandom);
            cycle();
            if (xfer_seen) n++;
`ifdef LANE_RR_ARBITER_XFER_CNT_EN
            if (force_rel) fp++;
`endif
            if (prev_busy && !bus.busy) break;
            prev_busy = bus.busy;
        end
        chk("hold_xfers", 32'(n), 32'(MAX_HOLD));
`ifdef LANE_RR_ARBITER_XFER_CNT_EN
        chk("hold_xfer_count", 32'(xfer_count), 32'(MAX_HOLD));
`endif
        cycle();
        chk("regrant_busy", 32'(bus.busy), 32'd1);
        chk("regrant_id", 32'(bus.grant_id), 32'd2);
`ifdef LANE_RR_ARBITER_XFER_CNT_EN
        for (int c = 0; c < 3; c++) begin
            cycle();
            if (force_rel) fp++;
        end
        chk("force_pulses", 32'(fp), 32'd1);
`endif

        // Owner 0 with out_ready toggling.
        do_reset();
        bus.req_valid = 4'b0001; bus.req_last = '0; bus.req_data = '0; bus.out_ready = 1'b0;
        cycle();
        n = 0;
        for (int c = 0; c < 4; c++) begin
            bus.out_ready = (c % 2 == 0);
            bus.req_valid = (n < 2) ? 4'b0001 : 4'b0000;
            bus.req_data[0 +: DW] = (n == 0) ? 2'b01 : 2'b10;
            bus.req_last[0] = (n == 1);
            cycle();
            if (xfer_seen) n++;
        end
        chk("toggle_xfers", 32'(n), 32'd2);
        chk("toggle_release", 32'(bus.busy), 32'd0);

        // Reset mid-burst of owner 3; requester 0 wins afterwards.
        do_reset();
        bus.req_valid = 4'b1000; bus.req_last = '0; bus.out_ready = 1'b1;
        cycle();
        cycle();
        bus.req_valid = 4'b1001;
        rst = 1'b1;
        cycle();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_grant", 32'(bus.grant_id), 32'd0);
        rst = 1'b0;
        cycle();
        chk("post_rst_grant", 32'(bus.grant_id), 32'd0);
        chk("post_rst_busy", 32'(bus.busy), 32'd1);

        // Random traffic.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bus.req_valid = NUM_REQ'($urandom);
            bus.req_last  = NUM_REQ'($urandom);
            bus.req_data  = (NUM_REQ*DW)'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

`ifdef LANE_RR_ARBITER_XFER_CNT_EN
        // Counter wrap: run up to 0xFFFE transfers, then watch three more.
        do_reset();
        verbose = 1'b0;
        bus.req_valid = 4'b0001; bus.req_last = '0; bus.out_ready = 1'b1;
        for (int c = 0; c < 80000 && m_xfer != 32'hFFFE; c++) cycle();
        chk("preload", 32'(xfer_count), 32'hFFFE);
        verbose = 1'b1;
        exp_w = '{16'hFFFF, 16'h0000, 16'h0001};
        got = 0;
        for (int c = 0; c < 10 && got < 3; c++) begin
            cycle();
            if (xfer_seen) begin
                chk("wrap", 32'(xfer_count), 32'(exp_w[got]));
                got++;
            end
        end
        chk("wrap_count", 32'(got), 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lane_rr_arbiter.md
Name: lane_rr_arbiter

Overview:
Round-robin arbiter that shares one DATA_WIDTH-bit lane datapath, a bank of per-bit pass-through lane instances, between NUM_REQ requesters.
- Sequences ownership of the datapath in bursts, using a valid/ready handshake on both sides.
- Sits in front of the lane datapath; the datapath input is driven from out_data.
- Forces rotation after MAX_HOLD transfers so that no requester starves the others.

Parameters:
NUM_REQ, 4, number of requesters (≥2)
DATA_WIDTH, 2, lane datapath width in bits
MAX_HOLD, 8, max transfers per grant before forced release (≥1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  NUM_REQ  per-requester valid
req_last  input  NUM_REQ  per-requester end-of-burst marker, qualified by valid
req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  per-requester ready
out_valid  output  1  valid toward lane datapath
out_data  output  DATA_WIDTH  data toward lane datapath
out_ready  input  1  datapath ready
grant_id  output  max(1,$clog2(NUM_REQ))  current owner index
busy  output  1  high while in GRANT state

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high.
- FSM states: IDLE, GRANT. Registered: state, grant_id, last_ptr, hold_cnt (width $clog2(MAX_HOLD+1)).
- Reset values:
  - state=IDLE, grant_id=0, last_ptr=NUM_REQ-1, hold_cnt=0.
  - Outputs: busy=0, req_ready=0, out_valid=0, out_data=0.
- IDLE:
  - If any req_valid is set, pick the first set requester searching from (last_ptr+1) mod NUM_REQ upward, with wrap-around.
  - Next cycle: state=GRANT, grant_id=winner, last_ptr=winner, hold_cnt=0.
  - If no req_valid is set, stay in IDLE.
  - One-cycle arbitration latency: a request seen at cycle N is first forwarded at cycle N+1.
- GRANT, combinational forward from owner g=grant_id:
  - out_valid=req_valid[g], out_data=req_data[g], req_ready[g]=out_ready.
  - All other req_ready bits are 0.
  - Zero-latency pass-through.
- Transfer: out_valid & out_ready. Each transfer increments hold_cnt.
- Release conditions:
  - Transfer with req_last[g]=1.
  - Transfer that makes hold_cnt reach MAX_HOLD.
  - On release, next state=IDLE.
- Release always costs one bubble cycle: IDLE is entered for exactly one cycle when a request is pending.
- Owner drops req_valid without last: the grant is held and no timeout applies. Other requesters wait.
- Simultaneous requests in IDLE: round-robin from last_ptr+1. After reset, requester 0 has highest priority.
- A single active requester is re-granted after each release, with one bubble between grants.
- req_last outside a transfer is ignored.
- MAX_HOLD=1 gives one transfer per grant.
- rst asserted mid-burst: all registers return to reset values on the next edge. The partial burst is abandoned and no transfer occurs in the reset cycle.
- out_data=0 whenever state=IDLE.

Optional Feature:
- Macro: LANE_RR_ARBITER_XFER_CNT_EN.
- When defined:
  - Adds output port xfer_count, 16 bits.
  - Counts every transfer and wraps from 0xFFFF to 0.
  - Reset value 0.
  - Adds output port force_rel, 1 bit, registered. Pulses high for one cycle after a release caused by MAX_HOLD rather than by req_last.
- When undefined: neither port nor any counter logic exists, and behaviour is otherwise identical.

Test Plan:
- Reset, then req_valid=4'b0000 for 5 cycles -> busy=0, req_ready=0, out_valid=0, grant_id=0 throughout.
- req_valid=4'b1010 simultaneously with out_ready=1, each burst 2 beats (last on 2nd) -> grant 1 first, then after 1 bubble grant 3; data on out_data matches per beat; grants alternate 1,3,1,3.
- Requester 2 holds valid, never asserts last, out_ready=1, MAX_HOLD=8 -> exactly 8 transfers, busy drops for 1 cycle, requester 2 re-granted; with macro, force_rel pulses once and xfer_count=8.
- Owner 0 with out_ready toggling 1,0,1,0 and data 2'b01,2'b10 with last on 2nd -> req_ready[0] mirrors out_ready, 2 transfers in 4 cycles, then release.
- Owner 3 mid-burst (1 beat done), rst high 1 cycle while requesters 0 and 3 stay valid -> outputs at reset values during reset; after reset, requester 0 is granted first.
- Macro defined, xfer_count preloaded to 0xFFFE by running 65534 transfers, then 3 more transfers -> xfer_count reads 0xFFFF, 0x0000, 0x0001.
